// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard.
// Sequence: inhibit the clock, drive the start bit, shift 8 data bits, odd
// parity and stop on device falling clock edges, check the ack, then wait
// for both lines to return idle.
//
// Optional build macro:
//   PS2_HOST_TX_ACK_CHECK_EN - when defined, a high ack at edge 11 turns the
//                              completion into tx_error instead of tx_done.
//
// Ports:
//   CLK100MHz   - system clock
//   reset_n     - asynchronous active-low reset
//   tx_data     - command byte, latched on acceptance
//   tx_valid    - request; accepted when tx_valid & tx_ready
//   tx_ready    - high only while idle
//   tx_done     - one-cycle pulse on successful completion
//   tx_error    - one-cycle pulse on timeout or (optionally) bad ack
//   ps2_clk_in  - PS/2 clock line as seen on the pin
//   ps2_data_in - PS/2 data line as seen on the pin
//   ps2_clk_oe  - 1 pulls the PS/2 clock low
//   ps2_data_oe - 1 pulls the PS/2 data low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK100MHz,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CNT_W   = 22;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned IDX_W   = 4;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // Nine shift-state edges (2..10) follow the edge taken in REQ.
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(8);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ack_bad_q, ack_bad_d;
    logic [1:0]           clk_sync_q, clk_sync_d;
    logic [1:0]           data_sync_q, data_sync_d;
    logic                 clk_prev_q, clk_prev_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 clk_s_c;
    logic                 data_s_c;
    logic                 clk_fall_c;
    logic                 abort_c;

    assign clk_s_c    = clk_sync_q[1];
    assign data_s_c   = data_sync_q[1];
    assign clk_fall_c = clk_prev_q & ~clk_s_c;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        ack_bad_d   = ack_bad_q;
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_s_c;
        clk_oe_d    = 1'b0;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        abort_c     = 1'b0;

        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    // Frame is shifted out LSB first: data, odd parity, stop.
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    cnt_d     = '0;
                    ack_bad_d = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = REQ;
                end else begin
                    clk_oe_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                if (clk_fall_c) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[FRAME_W-1:1]};
                    idx_d     = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (clk_fall_c) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[FRAME_W-1:1]};
                    idx_d     = idx_q + IDX_W'(1);
                    cnt_d     = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ACK;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (clk_fall_c) begin
`ifdef PS2_HOST_TX_ACK_CHECK_EN
                    ack_bad_d = data_s_c;
`else
                    ack_bad_d = 1'b0;
`endif
                    cnt_d     = '0;
                    state_d   = WAIT_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_s_c && data_s_c) begin
                    done_d  = ~ack_bad_q;
                    error_d = ack_bad_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Device stopped responding: release the bus and report.
        if (abort_c) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
            cnt_d     = '0;
        end

        ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            idx_q       <= '0;
            ack_bad_q   <= 1'b0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            ack_bad_q   <= ack_bad_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
